lvm_mem: RTL and testbench

- Memory responder on the far side of the lvm-16 CPU bus.
- Serves instruction words for `pc` and data words for `addr`, and commits CPU stores of `cpu_out` when `write` is high.
- After reset, a loader FSM fills memory from a host stream while holding the CPU stalled. It then releases the CPU into run mode.
- Sits between the cpu block and the top-level/testbench host.

---
 rtl/lvm_mem.sv | 70 +++++++
 tb/tb_lvm_mem.sv | 138 +++++++++++++
 2 files changed

// File: rtl/lvm_mem.sv
// lvm_mem: lvm-16 memory responder with a host loader that stalls the CPU until loading ends.
// MEM_WRITE_PROTECT_EN drops CPU stores below PROT_TOP and raises a sticky fault.
module lvm_mem #(
  parameter int ADDR_W = 8,
  parameter int WIDTH = 16,
  parameter int PROT_TOP = 64,
  parameter logic [15:0] NOP_WORD = 16'h4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      pc,
  input  logic [15:0]      addr,
  input  logic [WIDTH-1:0] cpu_out,
  input  logic             write,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] data,
  output logic             hold,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             fault
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {LOAD, RUN} state_t;
  state_t state, next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0] load_ptr;
  logic [ADDR_W-1:0] pi, ai;
  logic blocked, store, unused;
  assign pi = pc[ADDR_W-1:0];
  assign ai = addr[ADDR_W-1:0];
  assign unused = ^{pc[15:ADDR_W], addr[15:ADDR_W]};
  assign hold = state == LOAD;
  assign load_ready = state == LOAD;
`ifdef MEM_WRITE_PROTECT_EN
  logic fault_q;
  assign blocked = write && (ai < ADDR_W'(PROT_TOP));
  always_ff @(posedge clk)
    if (!reset) fault_q <= 1'b0;
    else if (state == RUN && blocked) fault_q <= 1'b1;
  assign fault = fault_q;
`else
  assign blocked = 1'b0;
  assign fault = 1'b0;
`endif
  assign store = write && !blocked;
  always_comb begin
    next = state;
    next = (state == LOAD && load_valid && (load_last || load_ptr == (ADDR_W+1)'(DEPTH-1))) ? RUN : state;
  end
  always_ff @(posedge clk) state <= !reset ? LOAD : next;
  // Memory has no reset; the loader and CPU share one write port by state.
  always_ff @(posedge clk)
    if (reset && state == LOAD && load_valid) mem[load_ptr[ADDR_W-1:0]] <= load_data;
    else if (reset && state == RUN && store) mem[ai] <= cpu_out;
  always_ff @(posedge clk)
    if (!reset) begin
      load_ptr <= '0;
      instruction <= NOP_WORD;
      data <= '0;
    end else if (state == LOAD) begin
      instruction <= NOP_WORD;
      data <= '0;
      if (load_valid) load_ptr <= load_ptr + 1'b1;
    end else begin
      instruction <= (store && pi == ai) ? cpu_out : mem[pi];
      data <= store ? cpu_out : mem[ai];
    end
endmodule

// File: tb/tb_lvm_mem.sv
// tb_lvm_mem: randomized bench for lvm_mem against an array-based reference model.
module tb_lvm_mem;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 0, reset = 0, write = 0, hold, load_valid = 0, load_last = 0, load_ready, fault;
  logic [15:0] pc = 0, addr = 0, cpu_out = 0, instruction, data, load_data = 0;
  int compared = 0, mismatched = 0;
  lvm_mem dut (.clk(clk), .reset(reset), .pc(pc), .addr(addr), .cpu_out(cpu_out), .write(write),
    .instruction(instruction), .data(data), .hold(hold), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready), .fault(fault));
  always #5 clk = ~clk;

  logic [15:0] m [256];
  bit kn [256];
  logic [15:0] ei, ed, loaded [256];
  bit run, ik, dk, ef, on;
  int ptr;

  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      run = 0; ptr = 0; ei = 16'h4000; ed = 0; ik = 1; dk = 1; ef = 0; on = 1;
    end else if (!run) begin
      ei = 16'h4000; ed = 0; ik = 1; dk = 1;
      if (load_valid) begin
        m[ptr] = load_data; kn[ptr] = 1;
        if (load_last || ptr == 255) run = 1;
        ptr++;
      end
    end else begin
      int p, a;
      bit blk, st;
      p = int'(pc) % 256; a = int'(addr) % 256;
      blk = PROT && write && a < 64;
      if (blk) ef = 1;
      st = write && !blk;
      ei = (st && p == a) ? cpu_out : m[p]; ik = (st && p == a) || kn[p];
      ed = st ? cpu_out : m[a]; dk = st || kn[a];
      if (st) begin m[a] = cpu_out; kn[a] = 1; end
    end
  end

  always @(negedge clk) if (on) begin
    chk("hold", {15'b0, hold}, {15'b0, !run});
    chk("load_ready", {15'b0, load_ready}, {15'b0, !run});
    chk("fault", {15'b0, fault}, {15'b0, ef});
    if (ik) chk("instruction", instruction, ei);
    if (dk) chk("data", data, ed);
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic do_reset(); reset = 0; cyc(); reset = 1; endtask
  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      pc = 16'($urandom); addr = 16'($urandom); cpu_out = 16'($urandom);
      write = ($urandom % 3) == 0;
      load_valid = $urandom % 2; load_last = $urandom % 2; load_data = 16'($urandom);
      cyc();
    end
    write = 0; load_valid = 0; load_last = 0;
  endtask

  initial begin
    logic [15:0] w [3];
    int n;
    w[0] = 16'h4000; w[1] = 16'h6FFF; w[2] = 16'hF60B;
    do_reset();
    chk("rst_hold", {15'b0, hold}, 16'd1);
    chk("rst_ready", {15'b0, load_ready}, 16'd1);
    chk("rst_instr", instruction, 16'h4000);
    chk("rst_data", data, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = w[i]; load_last = i == 2;
      chk("ld_ready", {15'b0, load_ready}, 16'd1);
      cyc();
    end
    load_valid = 0; load_last = 0;
    chk("run_hold", {15'b0, hold}, 16'd0);
    chk("run_ready", {15'b0, load_ready}, 16'd0);
    pc = 1; cyc();
    chk("pc1_instr", instruction, 16'h6FFF);
    write = 1; addr = 100; cpu_out = 50; cyc();
    chk("fwd_data", data, 16'd50);
    write = 0; cyc();
    chk("rd_data", data, 16'd50);
    addr = 356; cyc();
    chk("alias_data", data, 16'd50);
    pc = 74; addr = 74; write = 1; cpu_out = 16'h2D00; cyc();
    chk("fwd_instr", instruction, 16'h2D00);
    write = 0;
    rand_run(300);
    do_reset();
    n = 0;
    for (int b = 0; b < 2000 && n < 256; b++) begin
      load_valid = $urandom % 4 != 0; load_data = 16'($urandom); load_last = 0;
      if (load_valid) begin loaded[n] = load_data; n++; end
      cyc();
    end
    load_valid = 1; load_data = 16'hDEAD;
    chk("full_ready", {15'b0, load_ready}, 16'd0);
    chk("full_hold", {15'b0, hold}, 16'd0);
    cyc(); load_valid = 0;
    pc = 255; addr = 0; cyc();
    chk("full_last", instruction, loaded[255]);
    chk("full_first", data, loaded[0]);
    write = 1; addr = 5; cpu_out = 5; cyc();
    write = 0; pc = 5; cyc();
    chk("prot_mem5", instruction, PROT ? loaded[5] : 16'd5);
    chk("prot_fault", {15'b0, fault}, {15'b0, PROT});
    write = 1; addr = 64; cpu_out = 16'h1234; cyc();
    write = 0; pc = 64; cyc();
    chk("prot_mem64", instruction, 16'h1234);
    chk("prot_sticky", {15'b0, fault}, {15'b0, PROT});
    do_reset();
    load_valid = 1; load_data = 16'hAAAA; cyc();
    load_data = 16'hBBBB; cyc();
    load_valid = 0; reset = 0; cyc(); reset = 1;
    chk("mid_hold", {15'b0, hold}, 16'd1);
    load_valid = 1; load_data = 16'hCCCC; load_last = 1; cyc();
    load_valid = 0; load_last = 0;
    pc = 0; addr = 1; cyc();
    chk("mid_mem0", instruction, 16'hCCCC);
    chk("mid_mem1", data, 16'hBBBB);
    rand_run(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
